// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants and hex decode helper
package seg7_pkg;

    // All segments off, active-low gfedcba
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low gfedcba patterns, entry 15 (F) first down to entry 0
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Pure table lookup so any display user can share it
    always_comb begin
        seg_n = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment scan driver
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic                    blink_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    frame_done
);

    localparam int RW = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int IW = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);

    logic [RW-1:0]             refresh_cnt;
    logic [IW-1:0]             idx;
    logic [BW-1:0]             blink_cnt;
    logic                      blink_phase;
    logic [4*NUM_DIGITS-1:0]   shadow_val;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic                      pending;
    logic [4*NUM_DIGITS-1:0]   active_val;
    logic [NUM_DIGITS-1:0]     active_dp;

    logic                      refresh_tc;
    logic                      frame_wrap;
    logic [NUM_DIGITS-1:0]     upper_zero;
    logic                      zero_run;
    logic [3:0]                cur_nibble;
    logic                      cur_dp;
    logic                      cur_mask;
    logic                      cur_upper_zero;
    logic [NUM_DIGITS-1:0]     onehot;
    logic [6:0]                cur_seg;
    logic                      dark;

    assign refresh_tc = (refresh_cnt == REFRESH_LAST);
    assign frame_wrap = refresh_tc && (idx == INDEX_LAST);

    // Dwell counter: how long the current digit stays driven
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (refresh_tc) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Digit index advances at each dwell terminal count, wrapping after the last digit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (refresh_tc) begin
            if (idx == INDEX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Shadow/active pair: new values only reach the display at a frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            active_val <= '0;
            active_dp  <= '0;
        end else if (frame_wrap) begin
            pending <= 1'b0;
            if (load) begin
                active_val <= value;
                active_dp  <= dp;
            end else if (pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
        end else if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp;
            pending    <= 1'b1;
        end
    end

    // Blink timer only runs while blinking is requested; phase 1 means dark
    always_ff @(posedge clk) begin
        if (!rst_n || !blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // upper_zero[i]: active nibbles i..top are all zero (walks down from the top digit)
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (active_val[4*i +: 4] == 4'h0);
            upper_zero[i] = zero_run;
        end
    end

    // Pick out everything belonging to the digit currently being scanned
    always_comb begin
        cur_nibble     = 4'h0;
        cur_dp         = 1'b0;
        cur_mask       = 1'b0;
        cur_upper_zero = 1'b0;
        onehot         = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nibble     = active_val[4*i +: 4];
                cur_dp         = active_dp[i];
                cur_mask       = blank_mask[i];
                cur_upper_zero = upper_zero[i];
                onehot[i]      = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg_n  (cur_seg)
    );

    // Digit 0 is never leading-zero suppressed so a zero value still shows "0"
    always_comb begin
        dark = cur_mask
            || (blink_en && blink_phase)
            || (lz_en && (idx != '0) && cur_upper_zero);
    end

    // Registered pin drive; a dark digit keeps its enable but lights nothing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            dig_n      <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= dark ? SEG_BLANK : cur_seg;
            dp_n       <= dark || !cur_dp;
            dig_n      <= ~onehot;
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int B  = 8;
    localparam int FR = N * R;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [15:0]  value;
    logic [3:0]   dp;
    logic [3:0]   blank_mask;
    logic         lz_en;
    logic         blink_en;
    logic [6:0]   seg_n;
    logic         dp_n;
    logic [3:0]   dig_n;
    logic         frame_done;

    int checks = 0;
    int passed = 0;

    int          n;
    int          bcount;
    logic [15:0] latest;
    logic [15:0] shown;
    logic [3:0]  latest_dp;
    logic [3:0]  shown_dp;
    logic [6:0]  seg_ref [16];

    logic [3:0]  cur_dp;
    logic [3:0]  cur_mask;
    logic        cur_lz;
    logic        cur_bl;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLINK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .blink_en   (blink_en),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .dig_n      (dig_n),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic ld, input logic [15:0] v,
                         input logic [3:0] d, input logic [3:0] m,
                         input logic lz, input logic bl);
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_dig;
        logic       e_fd;
        logic [3:0] nib;
        logic       dk;
        int         ix;
        rst_n      = rst;
        load       = ld;
        value      = v;
        dp         = d;
        blank_mask = m;
        lz_en      = lz;
        blink_en   = bl;
        if (!rst) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_dig = 4'hF;
            e_fd  = 1'b0;
        end else begin
            if ((n % FR) == 0 && n > 0) begin
                shown    = latest;
                shown_dp = latest_dp;
            end
            ix    = (n / R) % N;
            nib   = 4'(shown >> (4 * ix));
            dk    = m[ix] || (bl && ((bcount / B) % 2 == 1))
                 || (lz && ix > 0 && (shown >> (4 * ix)) == 16'h0);
            e_seg = dk ? 7'h7F : seg_ref[nib];
            e_dp  = dk ? 1'b1 : !shown_dp[ix];
            e_dig = ~(4'b0001 << ix);
            e_fd  = ((n % FR) == FR - 1);
        end
        @(posedge clk);
        if (!rst) begin
            n         = 0;
            bcount    = 0;
            latest    = '0;
            shown     = '0;
            latest_dp = '0;
            shown_dp  = '0;
        end else begin
            if (ld) begin
                latest    = v;
                latest_dp = d;
            end
            bcount = bl ? bcount + 1 : 0;
            n++;
        end
        @(negedge clk);
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dp));
        check("dig_n", 32'(dig_n), 32'(e_dig));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic idle(input int cnt);
        for (int k = 0; k < cnt; k++) cycle(1'b1, 1'b0, 16'h0, cur_dp, cur_mask, cur_lz, cur_bl);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        cur_dp = d;
        cycle(1'b1, 1'b1, v, d, cur_mask, cur_lz, cur_bl);
    endtask

    task automatic run_to_phase(input int ph);
        for (int k = 0; k < FR && (n % FR) != ph; k++) idle(1);
    endtask

    initial begin
        seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        n = 0; bcount = 0; latest = '0; shown = '0; latest_dp = '0; shown_dp = '0;
        cur_dp = '0; cur_mask = '0; cur_lz = 1'b0; cur_bl = 1'b0;

        // reset and idle scan
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        idle(32);

        // mid-frame load shows only from the next frame
        run_to_phase(6);
        do_load(16'h1234, 4'h0);
        idle(40);

        // leading-zero suppression on and off
        cur_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        idle(36);
        cur_lz = 1'b0;
        idle(20);

        // blink then drop
        do_load(16'h1234, 4'h0);
        cur_bl = 1'b1;
        idle(40);
        cur_bl = 1'b0;
        idle(8);

        // decimal point and per-digit blank
        cur_mask = 4'b0001;
        do_load(16'h1234, 4'b0010);
        idle(36);
        cur_mask = 4'b0000;

        // loads one cycle before wrap and on the wrap cycle
        run_to_phase(FR - 2);
        do_load(16'hAAAA, 4'h0);
        do_load(16'hBCDE, 4'h0);
        idle(20);

        // reset mid-frame discards a pending load
        run_to_phase(5);
        do_load(16'h9876, 4'hF);
        idle(2);
        cycle(1'b0, 1'b0, 16'h0, cur_dp, cur_mask, cur_lz, cur_bl);
        cur_dp = '0;
        idle(36);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic        rr;
            logic        ld;
            logic [15:0] v;
            if ((k % 50) == 0) cur_lz = 1'($urandom);
            if ($urandom_range(0, 29) == 0) cur_bl = ~cur_bl;
            cur_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rr = ($urandom_range(0, 199) != 0);
            ld = ($urandom_range(0, 7) == 0);
            v  = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h00F0) : 16'($urandom);
            if (ld) cur_dp = 4'($urandom);
            cycle(rr, ld, v, cur_dp, cur_mask, cur_lz, cur_bl);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
